// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: WIDTH-bit LED pattern engine driven by a 3-bit mode switch.
// The pattern advances once every TICK_DIV enabled clocks. A parallel load
// and a mode change both restart the prescaler, so the first step always
// lands TICK_DIV enabled clocks after either event. All outputs come from flops.
module led_pattern_ctrl #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic [2:0]       SW,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] LED,
  output logic [2:0]       Mode,
  output logic             Step
);

  // The prescaler is at least one bit wide, so TICK_DIV=1 still works.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_ROTL  = 3'b001,
    M_ROTR  = 3'b010,
    M_UP    = 3'b011,
    M_DOWN  = 3'b100,
    M_PING  = 3'b101,
    M_BLINK = 3'b110,
    M_FILL  = 3'b111
  } mode_e;

  mode_e          mode_q;
  logic [PW-1:0]  pcnt;
  logic           dir;      // ping-pong direction: 0 = moving up/left, 1 = right
  logic [WIDTH-1:0] nxt_led;
  logic           nxt_dir;

  assign Mode = mode_q;

  // Next LED value and direction if a step were taken this cycle in the current mode.
  always_comb begin
    nxt_led = LED;
    nxt_dir = dir;
    case (mode_q)
      M_HOLD:  nxt_led = LED;
      M_ROTL:  nxt_led = {LED[WIDTH-2:0], LED[WIDTH-1]};
      M_ROTR:  nxt_led = {LED[0], LED[WIDTH-1:1]};
      M_UP:    nxt_led = LED + WIDTH'(1);
      M_DOWN:  nxt_led = LED - WIDTH'(1);
      M_PING: begin
        if (LED == '0) begin
          // An empty bank would never move; reseed from the LSB.
          nxt_led = WIDTH'(1);
          nxt_dir = 1'b0;
        end else if (!dir) begin
          if (LED[WIDTH-1]) begin
            nxt_dir = 1'b1;
            nxt_led = LED >> 1;
          end else begin
            nxt_led = LED << 1;
          end
        end else begin
          if (LED[0]) begin
            nxt_dir = 1'b0;
            nxt_led = LED << 1;
          end else begin
            nxt_led = LED >> 1;
          end
        end
      end
      M_BLINK: nxt_led = ~LED;
      M_FILL:  nxt_led = (&LED) ? '0 : {LED[WIDTH-2:0], 1'b1};
    endcase
  end

  // Prioritised state update: reset, load, mode change, step, count, freeze.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      LED    <= WIDTH'(1);
      pcnt   <= '0;
      dir    <= 1'b0;
      mode_q <= M_HOLD;
      Step   <= 1'b0;
    end else if (Load) begin
      LED    <= Din;
      pcnt   <= '0;
      dir    <= 1'b0;
      mode_q <= mode_e'(SW);
      Step   <= 1'b0;
    end else if (mode_e'(SW) != mode_q) begin
      // dir is deliberately kept so ping-pong resumes its old direction.
      mode_q <= mode_e'(SW);
      pcnt   <= '0;
      Step   <= 1'b0;
    end else if (En && (pcnt == PMAX)) begin
      pcnt <= '0;
      Step <= 1'b1;
      LED  <= nxt_led;
      dir  <= nxt_dir;
    end else if (En) begin
      pcnt <= pcnt + PW'(1);
      Step <= 1'b0;
    end else begin
      Step <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: directed table of multi-cycle vectors followed by
// randomized traffic; every clock is also compared against a behavioural model.
module tb_led_pattern_ctrl;

  localparam int W    = 8;
  localparam int TDIV = 4;
  localparam int FULL = 1 << W;

  // ---------------- clock / reset ----------------
  logic         clk;
  logic         rst;
  logic         en;
  logic [2:0]   sw;
  logic         load;
  logic [W-1:0] din;
  logic [W-1:0] led;
  logic [2:0]   mode;
  logic         step;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  led_pattern_ctrl #(.WIDTH(W), .TICK_DIV(TDIV)) dut (
    .Clk  (clk),
    .Rst  (rst),
    .En   (en),
    .SW   (sw),
    .Load (load),
    .Din  (din),
    .LED  (led),
    .Mode (mode),
    .Step (step)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Counts enabled clocks since the last restart instead of mirroring a prescaler.
  int m_led  = 1;
  int m_dir  = 0;
  int m_mode = 0;
  int m_cnt  = 0;
  int m_step = 0;

  function automatic int step_value(input int v, input int md, inout int d);
    int r;
    r = v;
    case (md)
      0: r = v;
      1: r = (v * 2) % FULL + v / (FULL / 2);
      2: r = v / 2 + (v % 2) * (FULL / 2);
      3: r = (v + 1) % FULL;
      4: r = (v + FULL - 1) % FULL;
      5: begin
        if (v == 0) begin
          r = 1; d = 0;
        end else if (d == 0) begin
          if (v >= FULL / 2) begin d = 1; r = v / 2; end
          else r = v * 2;
        end else begin
          if (v % 2 == 1) begin d = 0; r = (v * 2) % FULL; end
          else r = v / 2;
        end
      end
      6: r = FULL - 1 - v;
      default: r = (v == FULL - 1) ? 0 : (v * 2 + 1) % FULL;
    endcase
    return r;
  endfunction

  task automatic model_clock();
    if (!rst) begin
      m_led = 1; m_cnt = 0; m_dir = 0; m_mode = 0; m_step = 0;
    end else if (load) begin
      m_led = int'(din); m_cnt = 0; m_dir = 0; m_mode = int'(sw); m_step = 0;
    end else if (int'(sw) != m_mode) begin
      m_mode = int'(sw); m_cnt = 0; m_step = 0;
    end else if (en) begin
      m_cnt++;
      if (m_cnt == TDIV) begin
        m_cnt  = 0;
        m_step = 1;
        m_led  = step_value(m_led, m_mode, m_dir);
      end else begin
        m_step = 0;
      end
    end else begin
      m_step = 0;
    end
  endtask

  // ---------------- driver ----------------
  // One clock with the currently driven inputs; outputs sampled 1 time unit after the edge.
  task automatic cycle();
    model_clock();
    @(posedge clk);
    #1;
    chk("model_led",  int'(led),  m_led);
    chk("model_mode", int'(mode), m_mode);
    chk("model_step", int'(step), m_step);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         rst;
    logic         en;
    logic [2:0]   sw;
    logic         load;
    logic [W-1:0] din;
    int           n;
    logic [W-1:0] eled;
    logic [2:0]   emode;
    logic         estep;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, input logic e, input logic [2:0] s,
                              input logic l, input logic [W-1:0] d, input int n,
                              input logic [W-1:0] el, input logic [2:0] em,
                              input logic es);
    vec_t v;
    v.rst = r; v.en = e; v.sw = s; v.load = l; v.din = d; v.n = n;
    v.eled = el; v.emode = em; v.estep = es;
    return v;
  endfunction

  int step_count;

  initial begin
    rst = 1'b0; en = 1'b1; sw = 3'b001; load = 1'b0; din = '0;

    // reset and rotate left
    vq.push_back(mk(0, 1, 3'b001, 0, 8'h00, 2, 8'h01, 3'b000, 0));
    vq.push_back(mk(1, 1, 3'b001, 0, 8'h00, 1, 8'h01, 3'b001, 0));
    vq.push_back(mk(1, 1, 3'b001, 0, 8'h00, 3, 8'h01, 3'b001, 0));
    vq.push_back(mk(1, 1, 3'b001, 0, 8'h00, 1, 8'h02, 3'b001, 1));
    vq.push_back(mk(1, 1, 3'b001, 0, 8'h00, 3, 8'h02, 3'b001, 0));
    vq.push_back(mk(1, 1, 3'b001, 0, 8'h00, 1, 8'h04, 3'b001, 1));
    vq.push_back(mk(1, 1, 3'b001, 0, 8'h00, 4, 8'h08, 3'b001, 1));
    vq.push_back(mk(1, 1, 3'b001, 0, 8'h00, 4, 8'h10, 3'b001, 1));
    vq.push_back(mk(1, 1, 3'b001, 0, 8'h00, 4, 8'h20, 3'b001, 1));
    vq.push_back(mk(1, 1, 3'b001, 0, 8'h00, 4, 8'h40, 3'b001, 1));
    vq.push_back(mk(1, 1, 3'b001, 0, 8'h00, 4, 8'h80, 3'b001, 1));
    vq.push_back(mk(1, 1, 3'b001, 0, 8'h00, 4, 8'h01, 3'b001, 1));
    // counter wrap up, then down after a mode change
    vq.push_back(mk(1, 1, 3'b011, 1, 8'hFE, 1, 8'hFE, 3'b011, 0));
    vq.push_back(mk(1, 1, 3'b011, 0, 8'h00, 4, 8'hFF, 3'b011, 1));
    vq.push_back(mk(1, 1, 3'b011, 0, 8'h00, 4, 8'h00, 3'b011, 1));
    vq.push_back(mk(1, 1, 3'b011, 0, 8'h00, 4, 8'h01, 3'b011, 1));
    vq.push_back(mk(1, 1, 3'b100, 0, 8'h00, 1, 8'h01, 3'b100, 0));
    vq.push_back(mk(1, 1, 3'b100, 0, 8'h00, 3, 8'h01, 3'b100, 0));
    vq.push_back(mk(1, 1, 3'b100, 0, 8'h00, 1, 8'h00, 3'b100, 1));
    vq.push_back(mk(1, 1, 3'b100, 0, 8'h00, 4, 8'hFF, 3'b100, 1));
    // ping-pong boundaries
    vq.push_back(mk(1, 1, 3'b101, 1, 8'h40, 1, 8'h40, 3'b101, 0));
    vq.push_back(mk(1, 1, 3'b101, 0, 8'h00, 4, 8'h80, 3'b101, 1));
    vq.push_back(mk(1, 1, 3'b101, 0, 8'h00, 4, 8'h40, 3'b101, 1));
    vq.push_back(mk(1, 1, 3'b101, 0, 8'h00, 4, 8'h20, 3'b101, 1));
    vq.push_back(mk(1, 1, 3'b101, 1, 8'h02, 1, 8'h02, 3'b101, 0));
    vq.push_back(mk(1, 1, 3'b101, 0, 8'h00, 4, 8'h04, 3'b101, 1));
    vq.push_back(mk(1, 1, 3'b101, 0, 8'h00, 4, 8'h08, 3'b101, 1));
    vq.push_back(mk(1, 1, 3'b101, 1, 8'h00, 1, 8'h00, 3'b101, 0));
    vq.push_back(mk(1, 1, 3'b101, 0, 8'h00, 4, 8'h01, 3'b101, 1));
    // enable freeze
    vq.push_back(mk(1, 1, 3'b001, 1, 8'h01, 1, 8'h01, 3'b001, 0));
    vq.push_back(mk(1, 1, 3'b001, 0, 8'h00, 2, 8'h01, 3'b001, 0));
    vq.push_back(mk(1, 0, 3'b001, 0, 8'h00, 10, 8'h01, 3'b001, 0));
    vq.push_back(mk(1, 1, 3'b001, 0, 8'h00, 1, 8'h01, 3'b001, 0));
    vq.push_back(mk(1, 1, 3'b001, 0, 8'h00, 1, 8'h02, 3'b001, 1));
    // fill from empty through full and back to empty
    vq.push_back(mk(1, 1, 3'b111, 1, 8'h00, 1, 8'h00, 3'b111, 0));
    vq.push_back(mk(1, 1, 3'b111, 0, 8'h00, 4, 8'h01, 3'b111, 1));
    vq.push_back(mk(1, 1, 3'b111, 0, 8'h00, 4, 8'h03, 3'b111, 1));
    vq.push_back(mk(1, 1, 3'b111, 0, 8'h00, 4, 8'h07, 3'b111, 1));
    vq.push_back(mk(1, 1, 3'b111, 0, 8'h00, 4, 8'h0F, 3'b111, 1));
    vq.push_back(mk(1, 1, 3'b111, 0, 8'h00, 4, 8'h1F, 3'b111, 1));
    vq.push_back(mk(1, 1, 3'b111, 0, 8'h00, 4, 8'h3F, 3'b111, 1));
    vq.push_back(mk(1, 1, 3'b111, 0, 8'h00, 4, 8'h7F, 3'b111, 1));
    vq.push_back(mk(1, 1, 3'b111, 0, 8'h00, 4, 8'hFF, 3'b111, 1));
    vq.push_back(mk(1, 1, 3'b111, 0, 8'h00, 4, 8'h00, 3'b111, 1));
    // blink
    vq.push_back(mk(1, 1, 3'b110, 1, 8'hA5, 1, 8'hA5, 3'b110, 0));
    vq.push_back(mk(1, 1, 3'b110, 0, 8'h00, 4, 8'h5A, 3'b110, 1));
    vq.push_back(mk(1, 1, 3'b110, 0, 8'h00, 4, 8'hA5, 3'b110, 1));
    // load in the would-be step cycle, then reset in the would-be step cycle
    vq.push_back(mk(1, 1, 3'b110, 1, 8'h33, 1, 8'h33, 3'b110, 0));
    vq.push_back(mk(1, 1, 3'b110, 0, 8'h00, 3, 8'h33, 3'b110, 0));
    vq.push_back(mk(1, 1, 3'b110, 1, 8'h3C, 1, 8'h3C, 3'b110, 0));
    vq.push_back(mk(1, 1, 3'b110, 0, 8'h00, 3, 8'h3C, 3'b110, 0));
    vq.push_back(mk(0, 1, 3'b110, 0, 8'h00, 1, 8'h01, 3'b000, 0));
    // hold mode still pulses Step; rotate right wraps the LSB to the MSB
    vq.push_back(mk(1, 1, 3'b000, 0, 8'h00, 4, 8'h01, 3'b000, 1));
    vq.push_back(mk(1, 1, 3'b010, 0, 8'h00, 1, 8'h01, 3'b010, 0));
    vq.push_back(mk(1, 1, 3'b010, 0, 8'h00, 4, 8'h80, 3'b010, 1));

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; en = vq[i].en; sw = vq[i].sw;
      load = vq[i].load; din = vq[i].din;
      for (int k = 0; k < vq[i].n; k++) begin
        cycle();
        // during the plain rotate run, step must pulse only on every fourth clock
        if (i >= 2 && i <= 11 && k < vq[i].n - 1) chk("step_quiet", int'(step), 0);
      end
      chk($sformatf("vec%0d_led", i),  int'(led),  int'(vq[i].eled));
      chk($sformatf("vec%0d_mode", i), int'(mode), int'(vq[i].emode));
      chk($sformatf("vec%0d_step", i), int'(step), int'(vq[i].estep));
    end

    // hand sequence: TICK_DIV-aligned step rate over a long rotate run
    rst = 1'b1; en = 1'b1; sw = 3'b001; load = 1'b1; din = 8'h81;
    cycle();
    load = 1'b0;
    step_count = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (step) step_count++;
    end
    chk("step_rate", step_count, 40 / TDIV);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rst  = ($urandom_range(0, 99) != 0);
      load = ($urandom_range(0, 15) == 0);
      en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) sw = 3'($urandom_range(0, 7));
      din  = W'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Parametrised LED pattern engine: drives a WIDTH-bit LED bank from a 3-bit mode switch, advancing the pattern once every TICK_DIV enabled clocks. It succeeds the fixed 8-LED, manually clocked switch/LED top-level exercise. It adds:
- configurable width and step rate;
- parallel load;
- ping-pong and fill modes;
- a registered mode/step status.

It sits directly between the board switches/buttons and the LED pins.

## Interface
- WIDTH, 8, LED bank width; legal range is WIDTH >= 2.
- TICK_DIV, 4, enabled clocks per pattern step; legal range is TICK_DIV >= 1.
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  reset; one clock, reset is synchronous and active-low.
- En  input  1  step enable; the prescaler advances only while En=1.
- SW  input  3  mode select; sampled every clock.
- Load  input  1  parallel load strobe.
- Din  input  WIDTH  parallel load value.
- LED  output  WIDTH  pattern register, driven directly from a flop.
- Mode  output  3  currently applied mode (registered copy of SW).
- Step  output  1  one-clock pulse, high in the cycle LED shows a new step value.

## Operation
Internal state:
- pattern register `LED`;
- prescaler `pcnt` of width clog2(TICK_DIV), at least 1 bit;
- direction flag `dir` (0 = left/up, 1 = right);
- mode register `Mode`.

Each clock, the first matching rule below applies:
1. **Rst=0**: LED=1 (only LSB lit), pcnt=0, dir=0, Mode=000, Step=0.
2. **Load=1**: LED=Din, pcnt=0, dir=0, Mode=SW, Step=0.
3. **SW != Mode**: Mode=SW, pcnt=0, Step=0. LED and dir hold. No step occurs on a mode-change cycle.
4. **En=1 and pcnt==TICK_DIV-1**: pcnt=0, Step=1, LED updated per the mode table.
5. **En=1, otherwise**: pcnt+1, Step=0.
6. **En=0**: pcnt holds, Step=0.

Mode table (step action):
- **000 hold**: LED unchanged. Step still pulses.
- **001 rotate left**: LED = {LED[WIDTH-2:0], LED[WIDTH-1]}.
- **010 rotate right**: LED = {LED[0], LED[WIDTH-1:1]}.
- **011 count up**: LED+1 modulo 2^WIDTH. All-ones wraps to 0.
- **100 count down**: LED-1 modulo 2^WIDTH. 0 wraps to all-ones.
- **101 ping-pong**:
  - If LED==0: LED=1, dir=0.
  - Else if dir=0: if LED[WIDTH-1]=1 then dir=1 and LED=LED>>1 (zero fill); else LED=LED<<1 (zero fill).
  - dir=1 is the mirror image: if LED[0]=1 then dir=0 and LED=LED<<1; else LED=LED>>1.
  - dir is cleared only by reset or Load. It is retained across mode changes.
- **110 blink**: LED = ~LED.
- **111 fill**: if LED is all-ones then LED=0; else LED = {LED[WIDTH-2:0], 1'b1}.

Arithmetic is unsigned and WIDTH bits; carries and borrows are discarded.

## Timing
- All outputs are registered. No combinational path exists from any input to any output.
- Step latency: the first step occurs TICK_DIV enabled clocks after reset, Load or a mode change.
  - The new LED value and Step=1 appear together, in the same cycle.
- TICK_DIV=1: a step occurs on every enabled clock that is not a load, mode-change or reset cycle.
- Deasserting En freezes pcnt. Reasserting En resumes the count from the frozen value, not from 0.
- Load together with a SW change: Load wins, and Mode takes the new SW in the same cycle.
- Reset asserted mid-step (pcnt==TICK_DIV-1 with En=1): reset wins; Step=0 and LED=1.
- Mode and LED reflect their inputs one clock after the sampling edge.

## Test plan
- **Reset/rotate**: Rst=0 for 2 clocks, then Rst=1, SW=001, En=1, WIDTH=8, TICK_DIV=4.
  - Cycle after Rst deasserts: Mode=001, LED=8'h01 (mode-change cycle, no step).
  - Then LED=8'h02 four clocks later with Step=1. After 8 steps LED=8'h01 again.
  - Step is high exactly 1 clock in every 4.
- **Counter wrap**: Load Din=8'hFE, SW=011. Steps give FF, then 00, then 01.
  - Then switch to SW=100: no step on the change cycle; the next step gives 00, then FF.
- **Ping-pong boundary**: Load 8'h40, SW=101.
  - Steps give 80, 40, 20.
  - Load 8'h02, then steps give 04, 08.
  - Load 8'h00, then the first step gives 01.
- **Enable freeze**: SW=001, Load 8'h01, En=1 for 2 clocks, En=0 for 10 clocks, En=1.
  - The step arrives after exactly 2 more enabled clocks (LED=8'h02).
  - LED and pcnt are constant while En=0.
- **Fill/blink**:
  - SW=111 from LED=8'h00: steps give 01, 03, …, FF, then 00.
  - SW=110 from LED=8'hA5: steps give 5A, then A5.
- **Priority/mid-op reset**:
  - Load=1 in the same clock as pcnt==TICK_DIV-1: LED=Din, Step=0.
  - Rst=0 in a step cycle: LED=8'h01, Mode=000, Step=0.
